// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
// Runs one calculator operation per pushbutton request. It latches the
// operands and opcode, fires a single start pulse at the selected shared
// unit, waits for that unit's done, and keeps the result for the display
// path. Divide-by-zero, illegal opcodes and unit timeouts are reported on err.
module calc_op_sequencer #(
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic [2:0] btn,
  input  logic       go,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [7:0] radicand,
  output logic [2:0] unit_sel,
  output logic       unit_start,
  input  logic       unit_done,
  input  logic [7:0] unit_result,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic [1:0] err
);

  // The timer only has to count up to TIMEOUT-2, so clog2(TIMEOUT) bits are enough.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  // The last timer value seen in WAIT before giving up. With the timer
  // cleared in ISSUE this places the ERR cycle exactly TIMEOUT cycles
  // after the start pulse.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [2:0] OP_QUOTIENT  = 3'b010;
  localparam logic [2:0] OP_REMAINDER = 3'b100;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DIVZERO = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  logic [SYNC_STAGES-1:0] goSync_q;
  logic                   goPrev_q;
  logic                   goSynced;
  logic                   goEvt;

  logic [2:0]    state_q,       state_d;
  logic [3:0]    opA_q,         opA_d;
  logic [3:0]    opB_q,         opB_d;
  logic [7:0]    radicand_q,    radicand_d;
  logic [2:0]    unitSel_q,     unitSel_d;
  logic          unitStart_q,   unitStart_d;
  logic [7:0]    result_q,      result_d;
  logic          resultValid_q, resultValid_d;
  logic          busy_q,        busy_d;
  logic [1:0]    err_q,         err_d;
  logic [TW-1:0] timer_q,       timer_d;

  logic opcodeIllegal;
  logic divideByZero;

  // Bring the asynchronous pushbutton level into the clock domain and keep the previous synchronized level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      goSync_q <= '0;
      goPrev_q <= 1'b0;
    end else begin
      goSync_q[0] <= go;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        goSync_q[i] <= goSync_q[i-1];
      end
      goPrev_q <= goSynced;
    end
  end

  assign goSynced = goSync_q[SYNC_STAGES-1];
  assign goEvt    = goSynced & ~goPrev_q;

  // Opcodes 110 and 111 have no unit; quotient and remainder divide by A.
  assign opcodeIllegal = (unitSel_q[2:1] == 2'b11);
  assign divideByZero  = ((unitSel_q == OP_QUOTIENT) || (unitSel_q == OP_REMAINDER)) &&
                         (opA_q == 4'd0);

  // Sequencer next-state logic; every output is produced from a register so the display path sees glitch-free values.
  always_comb begin
    state_d       = state_q;
    opA_d         = opA_q;
    opB_d         = opB_q;
    radicand_d    = radicand_q;
    unitSel_d     = unitSel_q;
    unitStart_d   = 1'b0;
    result_d      = result_q;
    resultValid_d = resultValid_q;
    busy_d        = busy_q;
    err_d         = err_q;
    timer_d       = timer_q;

    case (state_q)
      S_IDLE: begin
        if (goEvt) begin
          opA_d         = sw[3:0];
          opB_d         = sw[7:4];
          radicand_d    = sw;
          unitSel_d     = btn;
          resultValid_d = 1'b0;
          err_d         = ERR_NONE;
          busy_d        = 1'b1;
          state_d       = S_LATCH;
        end
      end

      S_LATCH: begin
        if (opcodeIllegal) begin
          err_d   = ERR_ILLEGAL;
          busy_d  = 1'b0;
          state_d = S_ERR;
        end else if (divideByZero) begin
          err_d   = ERR_DIVZERO;
          busy_d  = 1'b0;
          state_d = S_ERR;
        end else begin
          unitStart_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (unit_done) begin
          result_d      = unit_result;
          resultValid_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = S_DONE;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = ERR_TIMEOUT;
          busy_d  = 1'b0;
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_ERR: begin
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and output registers; reset drops everything back to an idle, all-zero view immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      opA_q         <= '0;
      opB_q         <= '0;
      radicand_q    <= '0;
      unitSel_q     <= '0;
      unitStart_q   <= 1'b0;
      result_q      <= '0;
      resultValid_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= ERR_NONE;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      opA_q         <= opA_d;
      opB_q         <= opB_d;
      radicand_q    <= radicand_d;
      unitSel_q     <= unitSel_d;
      unitStart_q   <= unitStart_d;
      result_q      <= result_d;
      resultValid_q <= resultValid_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      timer_q       <= timer_d;
    end
  end

  assign op_a         = opA_q;
  assign op_b         = opB_q;
  assign radicand     = radicand_q;
  assign unit_sel     = unitSel_q;
  assign unit_start   = unitStart_q;
  assign result       = result_q;
  assign result_valid = resultValid_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer
// Directed and randomized requests against calc_op_sequencer. The bench plays
// the role of the arithmetic units and predicts results and error codes from
// the switch/button settings with plain arithmetic.
module tb_calc_op_sequencer;

  localparam int TIMEOUT = 64;
  localparam int SYNC    = 2;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw;
  logic [2:0] btn;
  logic       go;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [7:0] radicand;
  logic [2:0] unit_sel;
  logic       unit_start;
  logic       unit_done;
  logic [7:0] unit_result;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;
  logic [1:0] err;

  int nCompared   = 0;
  int nMismatched = 0;
  int startCount  = 0;
  int startViol   = 0;
  logic [7:0] modelResult = 8'd0;

  calc_op_sequencer #(
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .btn         (btn),
    .go          (go),
    .op_a        (op_a),
    .op_b        (op_b),
    .radicand    (radicand),
    .unit_sel    (unit_sel),
    .unit_start  (unit_start),
    .unit_done   (unit_done),
    .unit_result (unit_result),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy),
    .err         (err)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count start pulses away from the active edge and note any pulse seen while the sequencer is not busy.
  always @(negedge clk) begin
    if (unit_start === 1'b1) begin
      startCount++;
      if (busy !== 1'b1) startViol++;
    end
  end

  // Expected unit result for a request: A = sw[3:0], B = sw[7:4], A is the divisor.
  function automatic logic [7:0] refResult(input logic [7:0] s, input logic [2:0] op);
    int a = s[3:0];
    int b = s[7:4];
    int r = 0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = (a != 0) ? b / a : 0;
      3'd3: r = a * b;
      3'd4: r = (a != 0) ? b % a : 0;
      3'd5: for (int k = 0; k < 16; k++) if (k * k <= int'(s)) r = k;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  // Expected error code for a request.
  function automatic logic [1:0] refErr(input logic [7:0] s, input logic [2:0] op);
    if (op >= 3'd6) return 2'b10;
    if ((op == 3'd2 || op == 3'd4) && s[3:0] == 4'd0) return 2'b01;
    return 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nCompared++;
    assert (obs === exp)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete request: drive go, follow the sequencer cycle by cycle and play the selected unit.
  task automatic applyStimulus(input string tag, input logic [7:0] swV, input logic [2:0] btnV,
                               input int delay, input bit timeoutMode, input bit disturb,
                               input bit holdGo);
    logic [1:0] expErr;
    logic [7:0] expRes;
    int startsBefore;
    int busyHigh;
    expErr = refErr(swV, btnV);
    expRes = refResult(swV, btnV);
    startsBefore = startCount;
    sw  = swV;
    btn = btnV;
    go  = 1'b1;
    repeat (SYNC) tick();
    checkOutput({tag, "/idleBeforeLatch"}, 8'(busy), 8'd0);
    tick();
    checkOutput({tag, "/busyLatch"}, 8'(busy), 8'd1);
    checkOutput({tag, "/opA"}, 8'(op_a), 8'(swV[3:0]));
    checkOutput({tag, "/opB"}, 8'(op_b), 8'(swV[7:4]));
    checkOutput({tag, "/radicand"}, radicand, swV);
    checkOutput({tag, "/unitSel"}, 8'(unit_sel), 8'(btnV));
    checkOutput({tag, "/validCleared"}, 8'(result_valid), 8'd0);
    checkOutput({tag, "/errCleared"}, 8'(err), 8'd0);
    if (!holdGo) go = 1'b0;
    if (expErr != 2'b00) begin
      tick();
      checkOutput({tag, "/errCode"}, 8'(err), 8'(expErr));
      checkOutput({tag, "/errBusy"}, 8'(busy), 8'd0);
      checkOutput({tag, "/errValid"}, 8'(result_valid), 8'd0);
      checkOutput({tag, "/errResult"}, result, modelResult);
      repeat (3) tick();
      checkOutput({tag, "/noStart"}, 8'(startCount - startsBefore), 8'd0);
      checkOutput({tag, "/errHeld"}, 8'(err), 8'(expErr));
    end else begin
      tick();
      checkOutput({tag, "/startPulse"}, 8'(unit_start), 8'd1);
      if (timeoutMode) begin
        repeat (TIMEOUT - 1) tick();
        checkOutput({tag, "/notYetTimedOut"}, 8'(err), 8'd0);
        checkOutput({tag, "/stillBusy"}, 8'(busy), 8'd1);
        tick();
        checkOutput({tag, "/timeoutErr"}, 8'(err), 8'd3);
        checkOutput({tag, "/timeoutBusy"}, 8'(busy), 8'd0);
        checkOutput({tag, "/timeoutResult"}, result, modelResult);
        repeat (2) tick();
        unit_done   = 1'b1;
        unit_result = 8'hA5;
        repeat (3) tick();
        unit_done   = 1'b0;
        unit_result = 8'h00;
        checkOutput({tag, "/lateDoneErr"}, 8'(err), 8'd3);
        checkOutput({tag, "/lateDoneResult"}, result, modelResult);
        checkOutput({tag, "/lateDoneValid"}, 8'(result_valid), 8'd0);
        checkOutput({tag, "/oneStart"}, 8'(startCount - startsBefore), 8'd1);
      end else begin
        tick();
        checkOutput({tag, "/startOneCycle"}, 8'(unit_start), 8'd0);
        checkOutput({tag, "/waitValid"}, 8'(result_valid), 8'd0);
        if (disturb) begin
          sw  = ~swV;
          btn = btnV ^ 3'b011;
          go  = 1'b1;
          for (int i = 0; i < delay; i++) begin
            tick();
            if (i == 4) go = 1'b0;
          end
          checkOutput({tag, "/stableOpA"}, 8'(op_a), 8'(swV[3:0]));
          checkOutput({tag, "/stableOpB"}, 8'(op_b), 8'(swV[7:4]));
          checkOutput({tag, "/stableSel"}, 8'(unit_sel), 8'(btnV));
          checkOutput({tag, "/busyInWait"}, 8'(busy), 8'd1);
        end else begin
          repeat (delay) tick();
        end
        unit_done   = 1'b1;
        unit_result = expRes;
        tick();
        unit_done   = 1'b0;
        unit_result = 8'h00;
        checkOutput({tag, "/resultValid"}, 8'(result_valid), 8'd1);
        checkOutput({tag, "/result"}, result, expRes);
        checkOutput({tag, "/errNone"}, 8'(err), 8'd0);
        checkOutput({tag, "/doneBusy"}, 8'(busy), 8'd0);
        checkOutput({tag, "/oneStart"}, 8'(startCount - startsBefore), 8'd1);
        modelResult = expRes;
        if (disturb) begin
          repeat (8) tick();
          checkOutput({tag, "/droppedGoIdle"}, 8'(busy), 8'd0);
          checkOutput({tag, "/droppedNoStart"}, 8'(startCount - startsBefore), 8'd1);
          checkOutput({tag, "/validHeld"}, 8'(result_valid), 8'd1);
        end
        if (holdGo) begin
          busyHigh = 0;
          repeat (100) begin
            tick();
            if (busy) busyHigh++;
          end
          go = 1'b0;
          checkOutput({tag, "/holdNoRepeat"}, 8'(busyHigh), 8'd0);
          checkOutput({tag, "/holdOneStart"}, 8'(startCount - startsBefore), 8'd1);
        end
      end
    end
    go = 1'b0;
    repeat (4) tick();
  endtask

  // Directed scenarios, then random requests, then an asynchronous reset in the middle of WAIT.
  initial begin
    int startsAtReset;
    logic [7:0] rSw;
    logic [2:0] rBtn;
    rst_n       = 1'b0;
    go          = 1'b0;
    sw          = 8'h00;
    btn         = 3'b000;
    unit_done   = 1'b0;
    unit_result = 8'h00;
    tick();
    checkOutput("reset/outputs", {result_valid, busy, err, unit_start, 3'b000}, 8'd0);
    checkOutput("reset/result", result, 8'd0);
    checkOutput("reset/operands", {op_b, op_a}, 8'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    applyStimulus("add",      8'h53, 3'b000, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus("quoZero",  8'h70, 3'b010, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus("remZero",  8'h70, 3'b100, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus("illegal",  8'h12, 3'b111, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus("mulAfter", 8'h34, 3'b011, 2, 1'b0, 1'b0, 1'b0);
    applyStimulus("timeout",  8'hC8, 3'b101, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus("disturb",  8'h29, 3'b001, 8, 1'b0, 1'b1, 1'b0);
    applyStimulus("holdGo",   8'h62, 3'b000, 1, 1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 24; n++) begin
      rSw  = 8'($urandom);
      rBtn = 3'($urandom_range(0, 7));
      applyStimulus($sformatf("rand%0d", n), rSw, rBtn, $urandom_range(0, 4), 1'b0, 1'b0, 1'b0);
    end

    sw  = 8'h45;
    btn = 3'b011;
    go  = 1'b1;
    repeat (SYNC + 1) tick();
    go = 1'b0;
    tick();
    tick();
    startsAtReset = startCount;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncReset/flags", {result_valid, busy, err, unit_start, 3'b000}, 8'd0);
    checkOutput("asyncReset/result", result, 8'd0);
    checkOutput("asyncReset/operands", {op_b, op_a}, 8'd0);
    checkOutput("asyncReset/radicandSel", radicand | 8'(unit_sel), 8'd0);
    modelResult = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    unit_done   = 1'b1;
    unit_result = 8'hEE;
    repeat (3) tick();
    unit_done   = 1'b0;
    unit_result = 8'h00;
    checkOutput("lateDone/result", result, modelResult);
    checkOutput("lateDone/flags", {result_valid, busy, err, 4'b0000}, 8'd0);
    checkOutput("lateDone/noStart", 8'(startCount - startsAtReset), 8'd0);

    checkOutput("startOnlyWhileBusy", 8'(startViol), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Sequences one arithmetic operation per request across the calculator's shared datapath units: adder, subtractor, divider, multiplier and square root.
- Captures operands and opcode from the switches and buttons on a go request, issues a single start pulse to the selected unit, and waits for its done.
- Holds the result in a register for the LEDs and BCD display path.
- Flags divide-by-zero, illegal opcodes and unit timeouts.

Parameters:
- TIMEOUT, 64, max cycles to wait for unit_done after start before aborting (must be ≥2).
- SYNC_STAGES, 2, synchronizer flops on the go input.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  8  operand switches; sw[3:0] = A, sw[7:4] = B, sw[7:0] = radicand.
- btn  in  3  opcode select.
- go  in  1  asynchronous request level from the pushbutton.
- op_a  out  4  latched A to the units.
- op_b  out  4  latched B to the units.
- radicand  out  8  latched sw[7:0] to the square root unit.
- unit_sel  out  3  latched opcode, which steers the unit_result mux externally.
- unit_start  out  1  one-cycle start pulse.
- unit_done  in  1  completion from the selected unit; sampled only in WAIT.
- unit_result  in  8  result of the selected unit; valid when unit_done=1.
- result  out  8  registered result.
- result_valid  out  1  high while result holds a completed value.
- busy  out  1  high from LATCH through WAIT inclusive.
- err  out  2  00 none, 01 divide-by-zero, 10 illegal opcode, 11 timeout.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: op_a, op_b, radicand, unit_sel, unit_start, result, result_valid, busy, err. Sync chain and timer cleared.
- go passes through SYNC_STAGES flops and a rising-edge detector. go_evt is a one-cycle pulse per rising edge. Holding go high produces no repeat.
- Opcodes (btn): 000 add, 001 sub, 010 quotient, 011 multiply, 100 remainder, 101 sqrt, 110 and 111 illegal.
- IDLE:
  - On go_evt, latch sw into op_a/op_b/radicand and btn into unit_sel.
  - Clear result_valid and err.
  - Go to LATCH.
- LATCH (1 cycle): busy=1, then check the latched values.
  - Illegal opcode → ERR with err=10.
  - Opcode 010 or 100 with op_a=0 → ERR with err=01. The unit is never started.
  - Otherwise → ISSUE.
- ISSUE (1 cycle): unit_start=1, timer cleared, → WAIT.
- WAIT:
  - Timer increments each cycle.
  - unit_done=1: result<=unit_result, → DONE. done is taken in the same cycle even if the timer reaches TIMEOUT.
  - Timer reaches TIMEOUT-1 without done: → ERR with err=11. result is unchanged.
  - unit_done in any other state is ignored.
- DONE:
  - result_valid=1, busy=0, → IDLE.
  - result_valid stays 1 until the next accepted go_evt.
- ERR:
  - busy=0, result_valid=0, result unchanged, err held, → IDLE.
  - err clears on the next accepted go_evt.
- Minimum latency: go_evt cycle to result_valid is 4 cycles when unit_done arrives the cycle after start (IDLE→LATCH→ISSUE→WAIT→DONE).
- go_evt while busy is dropped, not queued. The latched operands do not change mid-operation even if sw/btn change.
- Only one unit_start pulse per accepted request. unit_start is never high outside ISSUE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A late unit_done after reset is ignored.
- result is 8-bit; unit_result is passed through without modification. Width handling is the responsibility of the units.

Test Plan:
- Add: sw=8'h53, btn=000, go pulse; unit_done one cycle after start with unit_result=8'h08 → exactly one unit_start, result=8'h08, result_valid 4 cycles after go_evt, err=00.
- Divide by zero: sw=8'h70 (A=0), btn=010, go → no unit_start, err=01, result_valid=0, busy back to 0 after the LATCH cycle. Same check with btn=100 → err=01.
- Illegal opcode: btn=111, go → err=10 and no start. A following valid go with btn=011, sw=8'h34, unit_result=8'h0C → err cleared, result=8'h0C.
- Timeout: TIMEOUT=64, btn=101, unit_done held 0 → err=11 exactly 64 cycles after unit_start, result unchanged from the previous operation. A unit_done injected afterwards is ignored.
- Busy drop and hold: second go and sw/btn changes during WAIT → op_a/op_b/unit_sel stable, no second start, single completion. Holding go high for 100 cycles → one request only.
- Async reset: assert rst_n=0 mid-WAIT between clock edges → all outputs 0 immediately. Release, then pulse unit_done → no state change.
